operand_fetch: RTL and testbench

- Multi-cycle operand stage directly upstream of the 16-bit ALU (ADD/SUB/AND/NOT, zero flag).
- Accepts one decoded operation per handshake and reads Rn and Rm in turn through a single register-file read port.
- Applies the 1-bit shift to the Rm operand and applies the A/B source selects.
- Presents Ain, Bin and the ALU opcode with a valid/ready handshake.

---
 rtl/operand_pkg.sv | 31 +++
 rtl/operand_shifter.sv | 30 +++
 rtl/operand_fetch.sv | 154 +++++++++++++++
 tb/tb_operand_fetch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_pkg
// Brief    : Shared constants and types for the operand fetch stage
//            (shift codes, ALU opcodes, FSM state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package operand_pkg;

  // Shift codes applied to the Rm operand
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  // ALU opcodes, carried through the stage untouched
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // Operand fetch sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ_A  = 2'd1,
    READ_B  = 2'd2,
    PRESENT = 2'd3
  } of_state_t;

endpackage
`default_nettype wire

// File: rtl/operand_shifter.sv
`default_nettype none
// ============================================================================
// Module   : operand_shifter
// Brief    : Combinational 1-bit shifter for the B operand
//            (none / LSL1 / LSR1 / ASR1, no carry out).
// Revision : 1.0 - initial release
// ============================================================================
module operand_shifter
  import operand_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] y
);

  // Select the shifted form of x; bits shifted out are simply dropped
  always_comb begin
    y = x;
    case (shift)
      SH_LSL1: y = {x[DATA_W-2:0], 1'b0};
      SH_LSR1: y = {1'b0, x[DATA_W-1:1]};
      SH_ASR1: y = {x[DATA_W-1], x[DATA_W-1:1]};
      default: y = x;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : Multi-cycle operand stage ahead of the ALU. Reads Rn then Rm
//            through one register-file read port, shifts Rm, applies the
//            A/B source selects and presents Ain/Bin/opcode on a valid/ready
//            handshake. One operation in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch
  import operand_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rn,
  input  logic [ADDR_W-1:0] in_rm,
  input  logic [1:0]        in_shift,
  input  logic              in_asel,
  input  logic              in_bsel,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_aluop,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ain,
  output logic [DATA_W-1:0] out_bin,
  output logic [1:0]        out_aluop
);

  of_state_t          r_state;
  logic [ADDR_W-1:0]  r_rm;
  logic [1:0]         r_shift;
  logic               r_asel;
  logic               r_bsel;
  logic [IMM_W-1:0]   r_imm;
  logic [1:0]         r_aluop;
  logic [DATA_W-1:0]  r_a;
  logic [ADDR_W-1:0]  r_raddr;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_ain;
  logic [DATA_W-1:0]  r_bin;
  logic [1:0]         r_out_aluop;

  logic [DATA_W-1:0]  w_sext_in;
  logic [DATA_W-1:0]  w_sext_lat;
  logic [DATA_W-1:0]  w_shifted;

  // Immediate sign extension, both for the incoming op (direct-to-PRESENT
  // case) and for the latched op (after reading Rn only)
  assign w_sext_in  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign w_sext_lat = {{(DATA_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};

  operand_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .x     (rf_rdata),
    .shift (r_shift),
    .y     (w_shifted)
  );

  // Held low while reset is asserted so upstream never sees a phantom accept
  assign in_ready  = rst_n && (r_state == IDLE);
  assign rf_raddr  = r_raddr;
  assign out_valid = r_out_valid;
  assign out_ain   = r_ain;
  assign out_bin   = r_bin;
  assign out_aluop = r_out_aluop;

  // Sequencer: accept, read Rn, read Rm, present; read address and outputs
  // are loaded on the transition into the state that uses them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rm        <= '0;
      r_shift     <= SH_NONE;
      r_asel      <= 1'b0;
      r_bsel      <= 1'b0;
      r_imm       <= '0;
      r_aluop     <= '0;
      r_a         <= '0;
      r_raddr     <= '0;
      r_out_valid <= 1'b0;
      r_ain       <= '0;
      r_bin       <= '0;
      r_out_aluop <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rm    <= in_rm;
            r_shift <= in_shift;
            r_asel  <= in_asel;
            r_bsel  <= in_bsel;
            r_imm   <= in_imm;
            r_aluop <= in_aluop;
            if (!in_asel) begin
              r_raddr <= in_rn;
              r_state <= READ_A;
            end else if (!in_bsel) begin
              r_raddr <= in_rm;
              r_state <= READ_B;
            end else begin
              // Neither register needed: present immediately
              r_ain       <= '0;
              r_bin       <= w_sext_in;
              r_out_aluop <= in_aluop;
              r_out_valid <= 1'b1;
              r_state     <= PRESENT;
            end
          end
        end
        READ_A: begin
          r_a <= rf_rdata;
          if (!r_bsel) begin
            r_raddr <= r_rm;
            r_state <= READ_B;
          end else begin
            r_ain       <= rf_rdata;
            r_bin       <= w_sext_lat;
            r_out_aluop <= r_aluop;
            r_out_valid <= 1'b1;
            r_state     <= PRESENT;
          end
        end
        READ_B: begin
          r_ain       <= r_asel ? '0 : r_a;
          r_bin       <= w_shifted;
          r_out_aluop <= r_aluop;
          r_out_valid <= 1'b1;
          r_state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Self-checking bench for operand_fetch with a register-file
//            model and an arithmetic reference for shifts and immediates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rn, in_rm;
  logic [1:0]  in_shift;
  logic        in_asel, in_bsel;
  logic [4:0]  in_imm;
  logic [1:0]  in_aluop;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ain, out_bin;
  logic [1:0]  out_aluop;

  logic [15:0] regs [8];
  int          checks = 0;
  int          errors = 0;

  // Pending op driven during backpressure (must not be latched early)
  logic [2:0]  nx_rn, nx_rm;
  logic [1:0]  nx_shift, nx_aluop;
  logic        nx_asel, nx_bsel;
  logic [4:0]  nx_imm;

  assign rf_rdata = regs[rf_raddr];

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(16), .ADDR_W(3), .IMM_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_shift  (in_shift),
    .in_asel   (in_asel),
    .in_bsel   (in_bsel),
    .in_imm    (in_imm),
    .in_aluop  (in_aluop),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ain   (out_ain),
    .out_bin   (out_bin),
    .out_aluop (out_aluop)
  );

  // Reference shift: plain arithmetic on the unsigned value
  function automatic logic [15:0] m_shift(input logic [15:0] x, input logic [1:0] s);
    int v;
    v = int'(x);
    case (s)
      2'd1:    v = (v * 2) % 65536;
      2'd2:    v = v / 2;
      2'd3:    v = v / 2 + ((v >= 32768) ? 32768 : 0);
      default: v = v;
    endcase
    return 16'(v);
  endfunction

  // Reference sign extension: interpret the 5-bit field as -16..15
  function automatic logic [15:0] m_sext(input logic [4:0] imm);
    int v;
    v = int'(imm);
    if (v >= 16) v = v - 32;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Runs one op end to end.
  // stall: cycles of out_ready=0 in PRESENT; hold: drive nx_* op meanwhile.
  task automatic run_op(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                        input logic asel, input logic bsel, input logic [4:0] imm,
                        input logic [1:0] op, input int stall, input bit hold);
    logic [15:0] exp_a, exp_b, ha, hb;
    logic [2:0]  reads[$];
    int          n;
    exp_a = asel ? 16'h0000 : regs[rn];
    exp_b = bsel ? m_sext(imm) : m_shift(regs[rm], sh);
    reads = {};
    if (!asel) reads.push_back(rn);
    if (!bsel) reads.push_back(rm);

    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_rn = rn; in_rm = rm; in_shift = sh;
    in_asel = asel; in_bsel = bsel; in_imm = imm; in_aluop = op;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      if (n < reads.size()) chk("rf_raddr", 32'(rf_raddr), 32'(reads[n]));
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'(reads.size()));
    chk("ain", 32'(out_ain), 32'(exp_a));
    chk("bin", 32'(out_bin), 32'(exp_b));
    chk("aluop", 32'(out_aluop), 32'(op));
    ha = out_ain; hb = out_bin;
    for (int i = 0; i < stall; i++) begin
      if (hold) begin
        in_valid = 1'b1; in_rn = nx_rn; in_rm = nx_rm; in_shift = nx_shift;
        in_asel = nx_asel; in_bsel = nx_bsel; in_imm = nx_imm; in_aluop = nx_aluop;
      end
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ain", 32'(out_ain), 32'(ha));
      chk("hold_bin", 32'(out_bin), 32'(hb));
      chk("hold_aluop", 32'(out_aluop), 32'(op));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rn = '0; in_rm = '0; in_shift = '0; in_asel = 1'b0; in_bsel = 1'b0;
    in_imm = '0; in_aluop = '0;
    for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h1111);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ain", 32'(out_ain), 32'd0);
    chk("rst_bin", 32'(out_bin), 32'd0);
    chk("rst_aluop", 32'(out_aluop), 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Both registers read, ASR1
    regs[2] = 16'h0005; regs[3] = 16'h8003;
    run_op(3'd2, 3'd3, 2'b11, 1'b0, 1'b0, 5'd0, 2'b00, 0, 1'b0);
    chk("dir_asr_bin", 32'(m_shift(16'h8003, 2'b11)), 32'h0000C001);
    // Logical shifts
    run_op(3'd2, 3'd3, 2'b01, 1'b0, 1'b0, 5'd0, 2'b01, 0, 1'b0);
    run_op(3'd2, 3'd3, 2'b10, 1'b0, 1'b0, 5'd0, 2'b10, 1, 1'b0);
    // Immediate path, shift must be ignored
    run_op(3'd2, 3'd3, 2'b01, 1'b1, 1'b1, 5'b10110, 2'b11, 0, 1'b0);
    // One read only, each side
    run_op(3'd5, 3'd3, 2'b00, 1'b1, 1'b0, 5'd7, 2'b00, 0, 1'b0);
    run_op(3'd2, 3'd6, 2'b11, 1'b0, 1'b1, 5'b01111, 2'b01, 0, 1'b0);

    // Backpressure with a competing op held on the input
    nx_rn = 3'd4; nx_rm = 3'd5; nx_shift = 2'b10; nx_asel = 1'b0; nx_bsel = 1'b0;
    nx_imm = 5'd3; nx_aluop = 2'b10;
    regs[4] = 16'h1234; regs[5] = 16'hF00F;
    run_op(3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01, 4, 1'b1);
    run_op(nx_rn, nx_rm, nx_shift, nx_asel, nx_bsel, nx_imm, nx_aluop, 0, 1'b0);
    // Back-to-back with different registers
    run_op(3'd7, 3'd1, 2'b01, 1'b0, 1'b0, 5'd0, 2'b00, 0, 1'b0);

    // Reset mid-flow, asserted during READ_B
    chk("mf_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_rn = 3'd2; in_rm = 3'd3; in_shift = 2'b00;
    in_asel = 1'b0; in_bsel = 1'b0; in_imm = 5'd0; in_aluop = 2'b01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mf_valid", 32'(out_valid), 32'd0);
    chk("mf_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mf_rel_in_ready", 32'(in_ready), 32'd1);
    chk("mf_ain", 32'(out_ain), 32'd0);
    chk("mf_bin", 32'(out_bin), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mf_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized ops against the reference model
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
